// File: rtl/multiplicador_uc.sv
// Control unit for the shift-add multiplier datapath multiplicador_fd.
// Moore FSM: one CHECK/(ADD)/SHIFT pass per multiplier bit, with the
// iteration count owned by the datapath down-counter (status line zero).
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for start, ready=1, no strobes
// S_LOAD  | clear A, load B, Q and the iteration counter
// S_CHECK | inspect Q[0] (qlsb) to decide whether to add
// S_ADD   | A <= A + B
// S_SHIFT | shift {A,Q} right, decrement counter, exit when zero was seen
// S_DONE  | one-cycle done pulse, product valid on {A,Q}

module multiplicador_uc (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic qlsb,
   input  logic zero,
   output logic a_rst,
   output logic a_en,
   output logic a_ld,
   output logic b_en,
   output logic b_ld,
   output logic q_en,
   output logic q_ld,
   output logic cnt_en,
   output logic cnt_ld,
   output logic ready,
   output logic busy,
   output logic done
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_CHECK = 3'd2,
      S_ADD   = 3'd3,
      S_SHIFT = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t state;
   state_t state_nx;

   // Next-state selection; unused encodings fall back to IDLE.
   always_comb begin
      state_nx = S_IDLE;
      case (state)
         S_IDLE:  state_nx = start ? S_LOAD : S_IDLE;
         S_LOAD:  state_nx = S_CHECK;
         S_CHECK: state_nx = qlsb ? S_ADD : S_SHIFT;
         S_ADD:   state_nx = S_SHIFT;
         S_SHIFT: state_nx = zero ? S_DONE : S_CHECK;
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // State register plus outputs decoded from the state being entered, so
   // every output is a flop that always matches the current state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         a_rst  <= 1'b0;
         a_en   <= 1'b0;
         a_ld   <= 1'b0;
         b_en   <= 1'b0;
         b_ld   <= 1'b0;
         q_en   <= 1'b0;
         q_ld   <= 1'b0;
         cnt_en <= 1'b0;
         cnt_ld <= 1'b0;
         ready  <= 1'b1;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         state  <= state_nx;
         a_rst  <= (state_nx == S_LOAD);
         a_en   <= (state_nx == S_ADD) || (state_nx == S_SHIFT);
         a_ld   <= (state_nx == S_ADD);
         b_en   <= (state_nx == S_LOAD);
         b_ld   <= (state_nx == S_LOAD);
         q_en   <= (state_nx == S_LOAD) || (state_nx == S_SHIFT);
         q_ld   <= (state_nx == S_LOAD);
         cnt_en <= (state_nx == S_LOAD) || (state_nx == S_SHIFT);
         cnt_ld <= (state_nx == S_LOAD);
         ready  <= (state_nx == S_IDLE);
         busy   <= (state_nx == S_LOAD) || (state_nx == S_CHECK) ||
                   (state_nx == S_ADD)  || (state_nx == S_SHIFT);
         done   <= (state_nx == S_DONE);
      end
   end

endmodule

// File: doc/multiplicador_uc.md
# multiplicador_uc

Control unit for the shift-add multiplier datapath `multiplicador_fd`. A Moore FSM that accepts a `start` request, then drives the datapath's clear, load, shift and count strobes through one add/shift iteration per multiplier bit. It watches the datapath status lines `qlsb` and `zero`, and pulses `done` when the product `{A,Q}` is valid on `P_out`. Sits directly upstream of `multiplicador_fd`: every control input of the datapath is driven from here.

## Interface
- No parameters. The iteration count is set by the datapath counter, which loads `WIDTH-1`.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  request a multiplication; sampled only in IDLE
- `qlsb`  in  1  datapath Q[0]
- `zero`  in  1  datapath counter == 0
- `a_rst`  out  1  clear register A
- `a_en`, `a_ld`  out  1 each  A enable; load (1) / shift-right (0)
- `b_en`, `b_ld`  out  1 each  B enable; load
- `q_en`, `q_ld`  out  1 each  Q enable; load (1) / shift-right with A[0] in (0)
- `cnt_en`, `cnt_ld`  out  1 each  counter enable; load (1) / decrement (0)
- `ready`  out  1  high in IDLE
- `busy`  out  1  high in LOAD, CHECK, ADD, SHIFT
- `done`  out  1  one-cycle pulse; product valid

## Operation
- Register semantics:
  - `*_ld` is asserted only together with its `*_en`.
  - `*_en` alone means shift (A, Q) or decrement (counter).
- States: IDLE, LOAD, CHECK, ADD, SHIFT, DONE. State is registered; all outputs are decoded from state only (pure Moore).
- IDLE:
  - Outputs: `ready`=1; all others 0.
  - `start`=1 -> LOAD; else stay in IDLE.
- LOAD:
  - Outputs: `a_rst`=1; `b_en`=`b_ld`=1; `q_en`=`q_ld`=1; `cnt_en`=`cnt_ld`=1.
  - Next: CHECK.
- CHECK:
  - Outputs: no strobes.
  - `qlsb`=1 -> ADD; else -> SHIFT.
- ADD:
  - Outputs: `a_en`=`a_ld`=1, which loads A+B into A.
  - Next: SHIFT.
- SHIFT:
  - Outputs: `a_en`=1, `q_en`=1, `cnt_en`=1 (all with ld=0).
  - `zero`=1 (sampled before this edge's decrement) -> DONE; else -> CHECK.
  - A decrement issued in the final SHIFT wraps the counter. This is harmless: LOAD reloads it.
- DONE:
  - Outputs: `done`=1 for exactly one cycle.
  - Next: IDLE.
  - `P_out` stays stable afterwards, because no strobes fire in IDLE, until the next LOAD.
- Iterations: exactly WIDTH SHIFT states per operation. An ADD precedes a SHIFT iff `qlsb` was 1 in the preceding CHECK.
- `start` outside IDLE is ignored, with no queuing. If `start` is held high, IDLE is visited for one cycle between operations.
- Unused or illegal state encodings -> IDLE on the next edge.

## Timing
- Reset: on a `rst`=1 edge, state=IDLE. Outputs then become `ready`=1 and every other output 0. This holds from any state, including mid-operation; datapath contents are don't-care until the next LOAD.
- `rst` has priority over `start`.
- Latency, with `start` high in cycle 0 (IDLE):
  - LOAD occurs in cycle 1.
  - `done` is high in cycle 2 + 2·WIDTH + popcount(Q_in).
  - `ready` returns the following cycle.
- Per multiplier bit: 2 cycles (CHECK, SHIFT) for a 0, or 3 cycles (CHECK, ADD, SHIFT) for a 1.
- WIDTH=8 bounds: 18 cycles to `done` for Q=0x00, 26 cycles for Q=0xFF.
- `qlsb` and `zero` are sampled only at the end of CHECK and SHIFT respectively. They must be settled datapath register outputs by then, which holds because they are registered in `multiplicador_fd`.
- No combinational path from any input to any output.

## Test plan
- Reset: drive `rst`=1 from random mid-operation states (ADD, SHIFT) -> next cycle `ready`=1 and every strobe and `done`=0. `start`=1 held during `rst` -> stays IDLE.
- B=13, Q=11, WIDTH=8, with a behavioral datapath model -> state sequence is LOAD, then CHECK/ADD/SHIFT per bit of 0b00001011. `done` is high at cycle 2+16+3=21 and P_out=143.
- Q=0x00, B=0xFF -> no ADD state ever, `a_en`&&`a_ld` never high, `done` at cycle 18, P_out=0.
- Q=0xFF, B=0x01 -> exactly 8 ADD states, `done` at cycle 26, P_out=0x00FF.
- `start` held high continuously -> `done` pulses exactly one cycle, followed by one IDLE cycle and a new LOAD. `start` toggled during busy -> no effect on sequence or cycle count.
- Strobe legality: assert every cycle that `*_ld` implies `*_en`, that `ready`, `busy` and `done` are mutually exclusive, and that `cnt_en` is high exactly 9 times per operation (1 load plus 8 decrements).
